// File: rtl/calc_result_display.sv
// Captures the calculator result, converts it to BCD with a serial double-dabble
// FSM and drives a 4-digit multiplexed active-low seven-segment display.
module calc_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] LED_output_result,
  input  logic       LED_carry_out,
  input  logic       LED_overflow,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN,
  output logic       busy
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state;
  logic [2:0]  iter;
  logic [7:0]  cap_res;
  logic        cap_c, cap_v;
  logic [11:0] bcd, bcd_adj, bcd_nxt;
  logic [3:0]  d_hund, d_tens, d_ones;
  logic        d_c, d_v;
  logic [SW-1:0] scan_cnt;
  logic [1:0]  dig;
  logic [6:0]  seg_d;
  logic        dp_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // One double-dabble step: correct nibbles >=5, then shift in the next bit MSB-first.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++)
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    bcd_nxt = {bcd_adj[10:0], cap_res[3'd7 - iter]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      iter    <= '0;
      cap_res <= '0;
      cap_c   <= 1'b0;
      cap_v   <= 1'b0;
      bcd     <= '0;
      busy    <= 1'b0;
      d_hund  <= '0;
      d_tens  <= '0;
      d_ones  <= '0;
      d_c     <= 1'b0;
      d_v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ({LED_output_result, LED_carry_out, LED_overflow} != {cap_res, cap_c, cap_v}) begin
            cap_res <= LED_output_result;
            cap_c   <= LED_carry_out;
            cap_v   <= LED_overflow;
            bcd     <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd  <= bcd_nxt;
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= UPDATE;
        end
        UPDATE: begin
          d_hund <= bcd[11:8];
          d_tens <= bcd[7:4];
          d_ones <= bcd[3:0];
          d_c    <= cap_c;
          d_v    <= cap_v;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading-zero blanking on tens/hundreds; digit3 is the carry/overflow annunciator.
  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    case (dig)
      2'd0: seg_d = seg7(d_ones);
      2'd1: if (d_hund != 4'd0 || d_tens != 4'd0) seg_d = seg7(d_tens);
      2'd2: if (d_hund != 4'd0) seg_d = seg7(d_hund);
      2'd3: begin
        if (d_c) seg_d = 7'b1000110;
        dp_d = ~d_v;
      end
      default: seg_d = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig      <= '0;
      SEG      <= 7'h7F;
      DP       <= 1'b1;
      AN       <= 4'hF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig      <= dig + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      SEG <= seg_d;
      DP  <= dp_d;
      AN  <= ~(4'b0001 << dig);
    end
  end
endmodule

// File: tb/tb_calc_result_display.sv
// Random and directed checks of calc_result_display against a decimal-digit model.
module tb_calc_result_display;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] res;
  logic       cin, ovf;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;
  logic       busy;
  int total = 0;
  int bad   = 0;
  int n;
  logic [6:0] sg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  calc_result_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .LED_output_result(res), .LED_carry_out(cin),
    .LED_overflow(ovf), .SEG(SEG), .DP(DP), .AN(AN), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts busy-high samples starting from the current one, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      step();
    end
  endtask

  task automatic conv(output int cnt);
    step();
    wait_idle(cnt);
  endtask

  task automatic check_scan(input string tag, input int val, input bit c, input bit v, input int cycles);
    int h, t, o;
    logic [6:0] es;
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    for (int i = 0; i < cycles; i++) begin
      chk({tag, "_an_onehot"}, $countones(~AN), 1);
      case (AN)
        4'b1110: es = sg[o];
        4'b1101: es = (h == 0 && t == 0) ? 7'h7F : sg[t];
        4'b1011: es = (h == 0) ? 7'h7F : sg[h];
        default: es = c ? 7'b1000110 : 7'h7F;
      endcase
      chk({tag, "_seg"}, SEG, es);
      chk({tag, "_dp"}, DP, (AN == 4'b0111 && v) ? 1'b0 : 1'b1);
      step();
    end
  endtask

  task automatic scan_order();
    logic [3:0] s [24];
    logic [3:0] e;
    int f;
    for (int i = 0; i < 24; i++) begin
      s[i] = AN;
      step();
    end
    f = 1;
    while (f < 23 && s[f] == s[f-1]) f++;
    e = s[f];
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && i % 4 == 0) e = {e[2:0], e[3]};
      chk("scan_order", s[f+i], e);
    end
  endtask

  initial begin
    logic [9:0] prev, cur;
    rst_n = 1'b0; res = 8'd10; cin = 1'b0; ovf = 1'b0;
    step(); step();
    chk("rst_seg", SEG, 7'h7F);
    chk("rst_dp", DP, 1'b1);
    chk("rst_an", AN, 4'hF);
    chk("rst_busy", busy, 1'b0);

    // Release with non-zero input: first edge both shows '0' on digit0 and starts converting.
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("rel_an", AN, 4'b1110);
    chk("rel_seg", SEG, 7'h40);
    wait_idle(n);
    chk("lat_10", n, 9);
    step();
    check_scan("v10", 10, 0, 0, 16);
    scan_order();

    // Unchanged input must not reconvert.
    step(); step();
    chk("no_reconv", busy, 1'b0);

    res = 8'd255; cin = 1'b1; ovf = 1'b1;
    conv(n);
    chk("lat_255", n, 9);
    step();
    check_scan("v255", 255, 1, 1, 16);

    res = 8'd100; cin = 1'b0; ovf = 1'b0;
    conv(n);
    chk("lat_100", n, 9);
    step();
    check_scan("v100", 100, 0, 0, 16);

    // Mid-conversion change is ignored until the next IDLE cycle.
    res = 8'd7;
    step();
    step(); step();
    res = 8'd128;
    wait_idle(n);
    chk("lat_7", n, 7);
    step();
    chk("reconv_busy", busy, 1'b1);
    check_scan("v7", 7, 0, 0, 8);
    wait_idle(n);
    step();
    check_scan("v128", 128, 0, 0, 16);

    // Reset mid-conversion aborts without touching the display.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    check_scan("zero", 0, 0, 0, 4);
    res = 8'd99;
    step(); step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("abort_seg", SEG, 7'h7F);
    chk("abort_dp", DP, 1'b1);
    chk("abort_an", AN, 4'hF);
    chk("abort_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk("abort_disp_zero", SEG, 7'h40);
    chk("abort_reconv", busy, 1'b1);
    wait_idle(n);
    chk("lat_99", n, 9);
    step();
    check_scan("v99", 99, 0, 0, 16);

    prev = {8'd99, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      cur = 10'($urandom_range(0, 1023));
      if (cur == prev) cur[0] = ~cur[0];
      res = cur[9:2]; cin = cur[1]; ovf = cur[0];
      conv(n);
      chk("lat_rand", n, 9);
      step();
      check_scan("rand", int'(cur[9:2]), cur[1], cur[0], 16);
      prev = cur;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_result_display.md
CALC_RESULT_DISPLAY -- requirements
Module: calc_result_display

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles each digit stays enabled; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 LED_output_result  input  8  unsigned calculator result, driven by simple_calc.
REQ-005 LED_carry_out  input  1  calculator carry flag.
REQ-006 LED_overflow  input  1  calculator overflow flag.
REQ-007 SEG  output  7  active-low segments; SEG[0]=a through SEG[6]=g.
REQ-008 DP  output  1  active-low decimal point.
REQ-009 AN  output  4  active-low digit enables; AN[0] is the rightmost (ones) digit.
REQ-010 busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-011 The block SHALL hold a captured register {res[7:0], c, v} and a display register {hund, tens, ones, c, v}.
REQ-012 The FSM SHALL have three states: IDLE, CONVERT and UPDATE.
REQ-013 IDLE: if {LED_output_result, LED_carry_out, LED_overflow} differs from the captured register at an edge, that edge SHALL capture the inputs, clear the BCD accumulator and enter CONVERT.
REQ-014 CONVERT: each cycle SHALL perform one double-dabble iteration: add 3 to any BCD nibble >=5, then shift left one bit, taking in the next result bit MSB-first.
REQ-015 CONVERT SHALL last exactly 8 cycles, counted by a 3-bit iteration counter, and then go to UPDATE.
REQ-016 UPDATE: one cycle; SHALL load the display register from the BCD accumulator and captured flags, then return to IDLE.
REQ-017 Latency: when a change is sampled at edge E0, the display register SHALL be updated at edge E9; busy SHALL be high after E0 through E9 (9 cycles).
REQ-018 Input changes during CONVERT/UPDATE SHALL be ignored; the first IDLE cycle SHALL compare against the captured value and reconvert if it differs.
REQ-019 Conversion SHALL be exact for 0..255 (hund 0..2); no other arithmetic is performed.
REQ-020 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-021 AN SHALL be the one-hot active-low decode of the digit index; exactly one bit low at all times after reset.
REQ-022 SEG, DP and AN SHALL be registered and change on the same edge.
REQ-023 Digit0 SHALL show ones and is always lit.
REQ-024 Digit1 SHALL show tens, blanked (SEG=7'h7F) when hund=0 and tens=0.
REQ-025 Digit2 SHALL show hund, blanked when hund=0.
REQ-026 Digit3 SHALL show 'C' (SEG=7'b1000110) when the displayed c=1, and be blank otherwise.
REQ-027 DP SHALL be low only while digit3 is enabled and the displayed v=1.
REQ-028 Decimal segment codes, active-low gfedcba, SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
REQ-029 Scanning SHALL be independent of conversion; a display update mid-scan takes effect on the next digit refresh edge.

Reset
REQ-030 rst_n=0 at an edge SHALL set: FSM=IDLE; iteration counter=0; captured and display registers all zero; scan counter=0; digit index=0; busy=0; SEG=7'h7F; DP=1; AN=4'hF.
REQ-031 Reset asserted mid-CONVERT SHALL abort the conversion without updating the display register.
REQ-032 On the first edge after release, scanning SHALL start at digit 0 showing '0'. If the inputs are non-zero, that same edge SHALL start a conversion.

Verification (SCAN_DIV=4)
REQ-033 Reset, then inputs 8'd10, c=0, v=0 held -> busy high for 9 cycles; display hund=0, tens=1, ones=0; digit0 SEG=40, digit1 SEG=79, digits 2-3 blank, DP=1.
REQ-034 Input 8'd255, c=1, v=1 -> digits show 2,5,5 (SEG 24,12,12); digit3 SEG=46; DP=0 only while AN=4'b0111.
REQ-035 Change 8'd7 -> 8'd128 at E0+3 mid-conversion -> first update shows 7; the next IDLE cycle starts a new conversion; 9 cycles later the display shows 1,2,8.
REQ-036 Scan order: AN sequence 1110,1101,1011,0111 repeating, each held exactly 4 cycles, never two bits low.
REQ-037 rst_n low at E0+4 during conversion of 8'd99 -> all outputs at reset values and the display register unchanged from zero; after release the input is reconverted and the display shows 9,9.
REQ-038 Input 8'd100 -> hund=1, tens=0, ones=0; tens digit shown as 0 (SEG=40), not blanked.
